// File: rtl/dmem_if.sv
// Processor-to-data-memory request/response bundle.
// The master drives requests; the slave returns busy, valid, error and load data.
interface dmem_if;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2mem_data;
  logic [31:0] mem2proc_data;
  logic        mem2proc_valid;
  logic        mem2proc_busy;
  logic        mem2proc_error;

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2mem_data,
    input  mem2proc_data, mem2proc_valid, mem2proc_busy, mem2proc_error
  );

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2mem_data,
    output mem2proc_data, mem2proc_valid, mem2proc_busy, mem2proc_error
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Fixed-latency single-outstanding data memory: IDLE/WAIT/DONE FSM over a word array.
// Handshake: a LOAD/STORE presented in cycle c is accepted at the edge ending c when the FSM is
// IDLE or DONE; busy is high while in WAIT (request must be held); valid pulses for one cycle
// in cycle c+LATENCY, with error qualifying it.
module dmem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam bit SINGLE = (LATENCY == 1);
  localparam int CNT_I = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [3:0] CNT_INIT = CNT_I[3:0];

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q;
  logic            st_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     data_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];

  logic            is_load, is_store, accept;
  logic [AW-1:0]   in_idx;
  logic            in_err;
  logic            fin, fin_store, fin_err;
  logic [AW-1:0]   fin_idx;
  logic [31:0]     fin_data;

  assign is_load  = (bus.proc2Dmem_command == 2'd1);
  assign is_store = (bus.proc2Dmem_command == 2'd2);
  assign accept   = (is_load || is_store) && (state_q == IDLE || state_q == DONE);
  assign in_idx   = bus.proc2Dmem_addr[AW+1:2];
  assign in_err   = (bus.proc2Dmem_addr[1:0] != 2'b00) ||
                    ((bus.proc2Dmem_addr >> (AW + 2)) != 32'd0);

  // With LATENCY=1 the transaction completes at its own accept edge, so use the live request.
  assign fin       = SINGLE ? accept   : (state_q == WAIT && cnt_q == 4'd0);
  assign fin_store = SINGLE ? is_store : st_q;
  assign fin_err   = SINGLE ? in_err   : err_q;
  assign fin_idx   = SINGLE ? in_idx   : idx_q;
  assign fin_data  = SINGLE ? bus.proc2mem_data : data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = SINGLE ? DONE : WAIT;
        else        state_d = IDLE;
      end
      WAIT:    if (cnt_q == 4'd0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      st_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        st_q   <= is_store;
        idx_q  <= in_idx;
        data_q <= bus.proc2mem_data;
        err_q  <= in_err;
        cnt_q  <= CNT_INIT;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (fin && !fin_store) rdata_q <= fin_err ? 32'd0 : mem[fin_idx];
    end
  end

  // Storage is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (fin && fin_store && !fin_err) mem[fin_idx] <= fin_data;
  end

  assign bus.mem2proc_data  = rdata_q;
  assign bus.mem2proc_valid = (state_q == DONE);
  assign bus.mem2proc_busy  = (state_q == WAIT);
  assign bus.mem2proc_error = (state_q == DONE) && err_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a LATENCY=2 instance driven from a vector table plus
// hand-written back-to-back and reset-abort sequences, and a LATENCY=1 instance.
module tb_dmem_ctrl;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus0 ();
  dmem_if bus1 ();
  logic [1:0] dbg0, dbg1;

  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0));
  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(1))   dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the LATENCY=2 instance, request held through busy.
  task automatic txn(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_data, input int id);
    logic [31:0] e;
    bus0.proc2Dmem_command = cmd;
    bus0.proc2Dmem_addr    = addr;
    bus0.proc2mem_data     = wdata;
    exp_q.push_back(exp_data);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      if (c < LAT) begin
        check($sformatf("v%0d_busy_c%0d", id, c), 32'(bus0.mem2proc_busy), 32'd1);
        check($sformatf("v%0d_novalid_c%0d", id, c), 32'(bus0.mem2proc_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_valid", id), 32'(bus0.mem2proc_valid), 32'd1);
        check($sformatf("v%0d_busy_done", id), 32'(bus0.mem2proc_busy), 32'd0);
        check($sformatf("v%0d_error", id), 32'(bus0.mem2proc_error), 32'(exp_err));
        check($sformatf("v%0d_data", id), bus0.mem2proc_data, e);
      end
    end
    bus0.proc2Dmem_command = 2'd0;
    tick();
    check($sformatf("v%0d_single_pulse", id), 32'(bus0.mem2proc_valid), 32'd0);
    check($sformatf("v%0d_err_low", id), 32'(bus0.mem2proc_error), 32'd0);
    check($sformatf("v%0d_idle", id), 32'(dbg0), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{2'd1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{2'd1, 32'h0000_0013, 32'h0,         1'b1, 32'h0000_0000};
    vecs[3]  = '{2'd1, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000};
    vecs[4]  = '{2'd1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{2'd2, 32'h0000_1010, 32'hBAD0_BAD0, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{2'd2, 32'h0000_0012, 32'h7777_7777, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{2'd1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{2'd2, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{2'd2, 32'h0000_0014, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{2'd1, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[11] = '{2'd1, 32'h0000_0014, 32'h0,         1'b0, 32'h1234_5678};
    vecs[12] = '{2'd1, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
    vecs[13] = '{2'd2, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0000_0000};
    vecs[14] = '{2'd1, 32'h0000_0000, 32'h0,         1'b0, 32'h0BAD_F00D};

    bus0.proc2Dmem_command = 2'd0; bus0.proc2Dmem_addr = 32'd0; bus0.proc2mem_data = 32'd0;
    bus1.proc2Dmem_command = 2'd0; bus1.proc2Dmem_addr = 32'd0; bus1.proc2mem_data = 32'd0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_data",  bus0.mem2proc_data, 32'd0);
    check("rst_valid", 32'(bus0.mem2proc_valid), 32'd0);
    check("rst_busy",  32'(bus0.mem2proc_busy), 32'd0);
    check("rst_error", 32'(bus0.mem2proc_error), 32'd0);
    check("rst_state", 32'(dbg0), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Table-driven transactions
    foreach (vecs[i])
      txn(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_data, i);

    // Command 3 is ignored
    bus0.proc2Dmem_command = 2'd3;
    bus0.proc2Dmem_addr    = 32'h10;
    tick();
    check("cmd3_busy",  32'(bus0.mem2proc_busy), 32'd0);
    check("cmd3_valid", 32'(bus0.mem2proc_valid), 32'd0);
    check("cmd3_state", 32'(dbg0), 32'd0);
    bus0.proc2Dmem_command = 2'd0;

    // Back-to-back: STORE 0x20=1, then LOAD 0x20 presented in the DONE cycle
    bus0.proc2Dmem_command = 2'd2; bus0.proc2Dmem_addr = 32'h20; bus0.proc2mem_data = 32'h1;
    tick();
    check("b2b_st_busy", 32'(bus0.mem2proc_busy), 32'd1);
    tick();
    check("b2b_st_valid", 32'(bus0.mem2proc_valid), 32'd1);
    check("b2b_st_err",   32'(bus0.mem2proc_error), 32'd0);
    check("b2b_st_data",  bus0.mem2proc_data, 32'h0BAD_F00D);
    bus0.proc2Dmem_command = 2'd1; bus0.proc2Dmem_addr = 32'h20; bus0.proc2mem_data = 32'h0;
    tick();
    check("b2b_ld_nobubble", 32'(bus0.mem2proc_busy), 32'd1);
    check("b2b_ld_novalid",  32'(bus0.mem2proc_valid), 32'd0);
    tick();
    check("b2b_ld_valid", 32'(bus0.mem2proc_valid), 32'd1);
    check("b2b_ld_data",  bus0.mem2proc_data, 32'h1);
    bus0.proc2Dmem_command = 2'd0;
    tick();
    check("b2b_end_valid", 32'(bus0.mem2proc_valid), 32'd0);

    // Reset abort during WAIT
    txn(2'd2, 32'h30, 32'h1111_1111, 1'b0, 32'h1, 100);
    bus0.proc2Dmem_command = 2'd2; bus0.proc2Dmem_addr = 32'h30; bus0.proc2mem_data = 32'hA5A5_A5A5;
    tick();
    check("abort_busy", 32'(bus0.mem2proc_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_data",  bus0.mem2proc_data, 32'd0);
    check("abort_busy0", 32'(bus0.mem2proc_busy), 32'd0);
    check("abort_valid", 32'(bus0.mem2proc_valid), 32'd0);
    check("abort_err",   32'(bus0.mem2proc_error), 32'd0);
    bus0.proc2Dmem_command = 2'd0;
    tick();
    check("abort_hold_valid", 32'(bus0.mem2proc_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_no_pulse", 32'(bus0.mem2proc_valid), 32'd0);
    check("abort_state",    32'(dbg0), 32'd0);
    // Request presented right after release is accepted at the first edge
    txn(2'd1, 32'h30, 32'h0, 1'b0, 32'h1111_1111, 101);

    // LATENCY=1 instance
    bus1.proc2Dmem_command = 2'd2; bus1.proc2Dmem_addr = 32'h10; bus1.proc2mem_data = 32'h55;
    tick();
    check("l1_st_valid", 32'(bus1.mem2proc_valid), 32'd1);
    check("l1_st_busy",  32'(bus1.mem2proc_busy), 32'd0);
    check("l1_st_data",  bus1.mem2proc_data, 32'd0);
    bus1.proc2Dmem_command = 2'd1; bus1.proc2mem_data = 32'h0;
    tick();
    check("l1_ld_valid", 32'(bus1.mem2proc_valid), 32'd1);
    check("l1_ld_busy",  32'(bus1.mem2proc_busy), 32'd0);
    check("l1_ld_data",  bus1.mem2proc_data, 32'h55);
    bus1.proc2Dmem_addr = 32'h11;
    tick();
    check("l1_err_valid", 32'(bus1.mem2proc_valid), 32'd1);
    check("l1_err_flag",  32'(bus1.mem2proc_error), 32'd1);
    check("l1_err_data",  bus1.mem2proc_data, 32'd0);
    bus1.proc2Dmem_command = 2'd3; bus1.proc2Dmem_addr = 32'h10;
    tick();
    check("l1_cmd3_valid", 32'(bus1.mem2proc_valid), 32'd0);
    check("l1_cmd3_busy",  32'(bus1.mem2proc_busy), 32'd0);
    check("l1_cmd3_state", 32'(dbg1), 32'd0);
    tick();
    check("l1_cmd3_idle", 32'(bus1.mem2proc_valid), 32'd0);
    bus1.proc2Dmem_command = 2'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
